// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES key schedule, one 32-bit word per clock
// Optional feature macro: AES_KEYEXP_CACHE_EN (absorb a restart with an unchanged key)
module aes_key_expand #(
   parameter int Nk = 4,
   parameter int Nr = Nk + 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [32*Nk-1:0] key,
   output logic             busy,
   output logic             valid,
   output logic [127:0]     k_sch [0:Nr]
);
   localparam int         NW      = 4 * (Nr + 1);
   localparam logic [5:0] NK_W    = 6'(Nk);
   localparam logic [5:0] LAST_W  = 6'(NW - 1);
   localparam logic [2:0] POS_MAX = 3'(Nk - 1);

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] w [0:NW-1];
   logic [5:0]  idx;
   logic [2:0]  pos;
   logic [7:0]  rcon;
   logic        accept, cache_hit, last_word;
   logic [31:0] prev_w, sub_in, sub_out, temp, new_w;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   assign last_word = (state == EXPAND) && (idx == LAST_W);
   assign accept    = start && (state != EXPAND) && !cache_hit;

`ifdef AES_KEYEXP_CACHE_EN
   logic [32*Nk-1:0] key_cache;
   logic             cache_vld;

   assign cache_hit = (state == DONE) && start && cache_vld && (key == key_cache);

   // Remember the key being expanded; it only counts as cached once its schedule completes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_cache <= '0;
         cache_vld <= 1'b0;
      end else if (accept) begin
         key_cache <= key;
         cache_vld <= 1'b0;
      end else if (last_word) begin
         cache_vld <= 1'b1;
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and status decode; busy/valid come straight from the state register
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      valid     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = EXPAND;
         end
         EXPAND: begin
            busy = 1'b1;
            if (last_word) state_nxt = DONE;
         end
         DONE: begin
            valid = 1'b1;
            if (accept) state_nxt = EXPAND;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Next schedule word: the single SubWord sees RotWord(prev) at a key boundary, prev otherwise
   always_comb begin
      prev_w  = w[idx - 6'd1];
      sub_in  = (pos == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
      sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
      temp    = prev_w;
      if (pos == 3'd0)
         temp = sub_out ^ {rcon, 24'h0};
      else if (Nk == 8 && pos == 3'd4)
         temp = sub_out;
      new_w = w[idx - NK_W] ^ temp;
   end

   // Word store, index, position-in-key counter and round constant
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NW; k++) w[k] <= '0;
         idx  <= NK_W;
         pos  <= 3'd0;
         rcon <= 8'h01;
      end else if (accept) begin
         for (int k = 0; k < Nk; k++) w[k] <= key[32*(Nk-k)-1 -: 32];
         idx  <= NK_W;
         pos  <= 3'd0;
         rcon <= 8'h01;
      end else if (state == EXPAND) begin
         w[idx] <= new_w;
         idx    <= idx + 6'd1;
         pos    <= (pos == POS_MAX) ? 3'd0 : pos + 3'd1;
         if (pos == 3'd0) rcon <= xtime(rcon);
      end
   end

   // Present the word store as 128-bit round keys, first word in the MSBs
   always_comb begin
      for (int r = 0; r <= Nr; r++)
         k_sch[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - bench for aes_key_expand at Nk=4/6/8 against a FIPS-197 model
module tb_aes_key_expand;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         start4, start6, start8;
   logic [127:0] key4;
   logic [191:0] key6;
   logic [255:0] key8;
   logic         busy4, busy6, busy8;
   logic         valid4, valid6, valid8;
   logic [127:0] ks4 [0:10];
   logic [127:0] ks6 [0:12];
   logic [127:0] ks8 [0:14];

   int checks   = 0;
   int failures = 0;

   logic [7:0]  sbox_ref [0:255];
   logic [31:0] mw [0:59];

   always #5 clk = ~clk;

   aes_key_expand #(.Nk(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .key(key4),
                                    .busy(busy4), .valid(valid4), .k_sch(ks4));
   aes_key_expand #(.Nk(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .start(start6), .key(key6),
                                    .busy(busy6), .valid(valid6), .k_sch(ks6));
   aes_key_expand #(.Nk(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .key(key8),
                                    .busy(busy8), .valid(valid8), .k_sch(ks8));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model: GF(2^8) arithmetic and FIPS-197 key expansion
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d = {v, v};
      return d[15-n -: 8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int b = 0; b < 256; b++) begin
         inv = 8'h00;
         if (b != 0)
            for (int x = 1; x < 256; x++)
               if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
         sbox_ref[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] v);
      return {sbox_ref[v[31:24]], sbox_ref[v[23:16]], sbox_ref[v[15:8]], sbox_ref[v[7:0]]};
   endfunction

   function automatic logic [7:0] rcon_of(input int j);
      logic [7:0] r = 8'h01;
      for (int k = 1; k < j; k++) r = gmul(r, 8'h02);
      return r;
   endfunction

   task automatic model_expand(input int nk, input logic [255:0] kv);
      logic [31:0] t;
      int nw = 4 * (nk + 7);
      for (int i = 0; i < nk; i++) mw[i] = kv[32*(nk-i)-1 -: 32];
      for (int i = nk; i < nw; i++) begin
         t = mw[i-1];
         if (i % nk == 0)
            t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
         else if (nk > 6 && i % nk == 4)
            t = subw(t);
         mw[i] = mw[i-nk] ^ t;
      end
   endtask

   // ---------------- per-instance access helpers
   function automatic logic get_busy(input int nk);
      case (nk)
         4:       return busy4;
         6:       return busy6;
         default: return busy8;
      endcase
   endfunction

   function automatic logic get_valid(input int nk);
      case (nk)
         4:       return valid4;
         6:       return valid6;
         default: return valid8;
      endcase
   endfunction

   function automatic logic [127:0] get_ks(input int nk, input int r);
      case (nk)
         4:       return ks4[r];
         6:       return ks6[r];
         default: return ks8[r];
      endcase
   endfunction

   task automatic set_start(input int nk, input logic v);
      case (nk)
         4:       start4 = v;
         6:       start6 = v;
         default: start8 = v;
      endcase
   endtask

   task automatic set_key(input int nk, input logic [255:0] kv);
      case (nk)
         4:       key4 = kv[127:0];
         6:       key6 = kv[191:0];
         default: key8 = kv;
      endcase
   endtask

   function automatic logic [255:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Pulse start for one edge, then scramble key; returns half a cycle after the accepting edge
   task automatic pulse_start(input int nk, input logic [255:0] kv);
      @(negedge clk);
      set_key(nk, kv);
      set_start(nk, 1'b1);
      @(negedge clk);
      set_start(nk, 1'b0);
      set_key(nk, rand_key());
   endtask

   // Count cycles from the accepting edge to valid; optionally fire a start mid-run
   task automatic wait_valid(input int nk, input string tag, input int inject_at, input logic [255:0] inject_kv);
      int n = 0;
      check({tag, " busy"}, 128'(get_busy(nk)), 128'd1);
      while (!get_valid(nk) && n < 200) begin
         @(negedge clk);
         n++;
         if (n == inject_at) begin
            set_key(nk, inject_kv);
            set_start(nk, 1'b1);
         end else if (n == inject_at + 1) begin
            set_start(nk, 1'b0);
         end
      end
      check({tag, " latency"}, 128'(n), 128'(3 * nk + 28));
      check({tag, " busy at valid"}, 128'(get_busy(nk)), 128'd0);
   endtask

   task automatic check_sched(input int nk, input logic [255:0] kv, input string tag);
      model_expand(nk, kv);
      for (int r = 0; r <= nk + 6; r++)
         check($sformatf("%s ks[%0d]", tag, r), get_ks(nk, r),
               {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
   endtask

   task automatic check_reset_state(input int nk, input string tag);
      check({tag, " busy"}, 128'(get_busy(nk)), 128'd0);
      check({tag, " valid"}, 128'(get_valid(nk)), 128'd0);
      for (int r = 0; r <= nk + 6; r++)
         check($sformatf("%s ks[%0d]", tag, r), get_ks(nk, r), 128'h0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] kv, kv_a, kv_b, kv_c;
      int nks [3] = '{4, 6, 8};

      rst_n  = 1'b0;
      start4 = 1'b0;
      start6 = 1'b0;
      start8 = 1'b0;
      key4   = '0;
      key6   = '0;
      key8   = '0;
      build_sbox();
      repeat (3) @(negedge clk);
      foreach (nks[j]) check_reset_state(nks[j], $sformatf("reset nk%0d", nks[j]));
      rst_n = 1'b1;

      // Known-answer vectors
      kv = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
      pulse_start(4, kv);
      wait_valid(4, "kat128", -1, '0);
      check("kat128 ks[1]", ks4[1], 128'ha0fafe1788542cb123a339392a6c7605);
      check("kat128 ks[10]", ks4[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check_sched(4, kv, "kat128");

      kv = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
      pulse_start(6, kv);
      wait_valid(6, "kat192", -1, '0);
      check("kat192 ks[12]", ks6[12], 128'he98ba06f448c773c8ecc720401002202);
      check_sched(6, kv, "kat192");

      kv = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      pulse_start(8, kv);
      wait_valid(8, "kat256", -1, '0);
      check("kat256 ks[14]", ks8[14], 128'hfe4890d1e6188d0b046df344706c631e);
      check_sched(8, kv, "kat256");

      // Random keys, back-to-back restarts from DONE
      for (int it = 0; it < 3; it++) begin
         foreach (nks[j]) begin
            kv = rand_key();
            pulse_start(nks[j], kv);
            wait_valid(nks[j], $sformatf("rand%0d nk%0d", it, nks[j]), -1, '0);
            check_sched(nks[j], kv, $sformatf("rand%0d nk%0d", it, nks[j]));
         end
      end

      // start while busy is ignored
      kv_a = rand_key();
      kv_b = rand_key();
      pulse_start(4, kv_a);
      wait_valid(4, "ignore", 10, kv_b);
      check_sched(4, kv_a, "ignore");

      // Reset mid-expansion aborts to reset values
      pulse_start(4, kv_b);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_state(4, "abort");

      pulse_start(4, kv_b);
      wait_valid(4, "post-abort", -1, '0);
      check_sched(4, kv_b, "post-abort");

      // Restart in DONE with the same key
      pulse_start(4, kv_b);
`ifdef AES_KEYEXP_CACHE_EN
      for (int c = 0; c < 5; c++) begin
         check($sformatf("cache hit valid c%0d", c), 128'(valid4), 128'd1);
         check($sformatf("cache hit busy c%0d", c), 128'(busy4), 128'd0);
         @(negedge clk);
      end
      check_sched(4, kv_b, "cache hit");
      kv_c = rand_key();
      pulse_start(4, kv_c);
      check("cache miss valid", 128'(valid4), 128'd0);
      wait_valid(4, "cache miss", -1, '0);
      check_sched(4, kv_c, "cache miss");
`else
      kv_c = kv_b;
      check("same key valid drop", 128'(valid4), 128'd0);
      wait_valid(4, "same key", -1, '0);
      check_sched(4, kv_c, "same key");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES key-schedule generator, sitting directly upstream of the AES cipher datapath. Accepts a cipher key of Nk 32-bit words and produces all Nr+1 128-bit round keys as a parallel array, one schedule word per clock. The `k_sch` array and `valid` level are held stable for the cipher to consume until the next `start`.

## Interface
- `Nk`, default 4: key length in 32-bit words. Legal values are 4, 6 and 8 (AES-128/192/256).
- `Nr`, default Nk+6: number of rounds.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: begin expansion of `key`. Sampled only when `busy`=0.
- `key`  in  32*Nk: cipher key. Word w[0] is `key[32*Nk-1 -: 32]`. Byte order follows FIPS-197, with the first byte in the MSBs.
- `busy`  out  1: expansion in progress.
- `valid`  out  1: `k_sch` is complete and stable.
- `k_sch`  out  [127:0] x [0:Nr]: round keys. `k_sch[r]` = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits [127:96].

## Operation
- Total words Nw = 4*(Nr+1): 44, 52 or 60.
- FSM states:
  - IDLE: `busy`=0. Transitions: `start` → EXPAND.
  - EXPAND: `busy`=1. Transitions: word Nw-1 written → DONE.
  - DONE: `busy`=0, `valid`=1. Transitions: `start` → EXPAND.
- On accepting `start`:
  - Words w[0..Nk-1] are loaded from `key` in one cycle.
  - Index i is set to Nk; the position counter (i mod Nk) is set to 0; Rcon is set to 8'h01.
  - `valid` is cleared.
- EXPAND writes one word per cycle for i = Nk .. Nw-1:
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon, 24'h0}. Rcon then advances by xtime, giving 01,02,04,08,10,20,40,80,1b,36.
  - Else if Nk==8 and i mod Nk == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
- RotWord rotates bytes left: {b0,b1,b2,b3} → {b1,b2,b3,b0}. SubWord applies the AES S-box to each byte. Use one 4-byte S-box instance.
- The i mod Nk computation uses a wrapping counter, not a divider. The i counter is 6 bits.
- `start` while `busy`=1 is ignored; expansion continues unchanged.
- `start` in DONE restarts expansion; `valid` falls at the same edge.
- During EXPAND, `k_sch` words update as they are written. Their contents are not meaningful until `valid`=1.
- `key` is sampled only at the accepting edge. Later changes to `key` do not affect the running expansion.

## Timing
- Reset values: `busy`=0, `valid`=0, every `k_sch` entry 128'h0, FSM in IDLE, Rcon 8'h01.
- `rst_n`=0 mid-expansion aborts at the next edge and restores all reset values.
- Let E0 be the edge accepting `start`:
  - `busy`=1 from E0.
  - The last word is written at edge E0+(Nw-Nk). At that same edge `busy` falls and `valid` rises.
  - `valid` is therefore visible 40 cycles after E0 for Nk=4, 46 cycles for Nk=6, and 52 cycles for Nk=8.
- `valid` stays high until the next accepted `start` or reset.
- The combinational path per cycle is S-box → two XOR levels. No further pipelining is required.

## Configuration
- `AES_KEYEXP_CACHE_EN` defined:
  - The block holds a copy of the last fully expanded key plus a cache-valid flag. Reset and abort both clear the flag.
  - A `start` in DONE with `key` equal to the cached key is absorbed: no EXPAND, `valid` stays 1 without a glitch, `busy` stays 0, `k_sch` is untouched.
  - A differing key restarts normally.
- Not defined: every accepted `start` performs a full expansion. No key copy register is instantiated.

## Test plan
- Nk=4, key 2b7e1516 28aed2a6 abf71588 09cf4f3c → `valid` 40 cycles after start; `k_sch[1]`=a0fafe17 88542cb1 23a33939 2a6c7605; `k_sch[10]`=d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- Nk=6, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b → `valid` after 46 cycles; `k_sch[12]`=e98ba06f 448c773c 8ecc7204 01002202.
- Nk=8, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 → `valid` after 52 cycles; `k_sch[14]`=fe4890d1 e6188d0b 046df344 706c631e.
- Nk=4:
  - Assert `start` with a different key 10 cycles into an expansion → ignored; the first key's `k_sch[10]` is still correct.
  - Then `rst_n`=0 for one cycle at cycle 20 of a new run → `busy`=0, `valid`=0, `k_sch` all zero the next cycle.
  - A subsequent start still yields correct results.
- Nk=4, `valid`=1, `start` with the same key:
  - With `AES_KEYEXP_CACHE_EN`: `valid` stays 1 and `busy` stays 0.
  - Without the macro: `valid` falls, rises again after 40 cycles, and `k_sch` is identical.
